ahblite_iq_fetch_ctrl: RTL
==========================

Name: ahblite_iq_fetch_ctrl

Overview:
Multi-channel successor to the single-bit IQ fetch enable slave. It sits on the AHB-Lite matrix as a zero-wait-state register slave. Each of NUM_CH channels runs an IQ fetch of a programmed length: fetch_en[ch] is held high, fetch_ack[ch] beats are counted, and the channel stops on its own at the programmed length. Completion raises a per-channel interrupt status bit, and a maskable combined irq line is driven to the interrupt controller.

Parameters:
NUM_CH, 4, number of fetch channels (1..8)
CNT_W, 16, width of the per-channel length register and beat counter (1..32)

Ports:
HCLK  input  1  AHB clock
HRESETn  input  1  asynchronous active-low reset
HSEL  input  1  slave select
HADDR  input  32  address; only HADDR[7:2] decoded
HTRANS  input  2  transfer type; HTRANS[1]=1 means a valid transfer
HSIZE  input  3  ignored; word access assumed
HPROT  input  4  ignored
HWRITE  input  1  write/read
HWDATA  input  32  write data, sampled in the data phase
HREADY  input  1  bus ready
HREADYOUT  output  1  tied to 1
HRDATA  output  32  read data in the data phase
HRESP  output  1  tied to 0 (OKAY)
fetch_en  output  NUM_CH  per-channel fetch enable, registered
fetch_ack  input  NUM_CH  per-channel beat accept, one beat per high cycle
irq  output  1  OR of (IRQ_STAT & IRQ_MASK), registered

Behaviour:
- Clock is HCLK. Reset is HRESETn, asynchronous, active-low. All flops clear on reset: fetch_en=0, irq=0, all channels IDLE, LEN/CNT/IRQ_STAT/IRQ_MASK=0.
- Address phase is accepted when HSEL & HTRANS[1] & HREADY. The slave latches HADDR[7:2], HWRITE and a valid flag.
- The data phase is the next cycle. Writes take effect at the clock edge that ends the data phase, using HWDATA. Reads drive HRDATA combinationally from the latched address.
- Register map:
  - 0x00 START (WO): each bit ch written 1 requests a start.
  - 0x04 STOP (WO): each bit ch written 1 requests a stop.
  - 0x08 BUSY (RO): bit ch = 1 while channel ch is in RUN.
  - 0x0C IRQ_STAT (RW1C): completion flags.
  - 0x10 IRQ_MASK (RW).
  - 0x20+4*ch LEN[ch] (RW, CNT_W bits).
  - 0x40+4*ch CNT[ch] (RO): beats completed.
- Unmapped, out-of-range-channel and write-only addresses read as 0. Unused bits read 0. Writes to them are ignored.
- Per-channel FSM, IDLE -> RUN -> IDLE:
  - IDLE->RUN on a START bit with LEN[ch]!=0. CNT[ch] clears to 0. fetch_en[ch]=1 from the edge ending the data phase.
  - A START bit with LEN[ch]=0 is ignored: no state change, no irq.
  - A START bit while in RUN is ignored; the counter is not restarted.
  - In RUN, each cycle with fetch_ack[ch]=1 increments CNT[ch].
  - On an ack with CNT[ch]==LEN[ch]-1: CNT becomes LEN, the state goes to IDLE, fetch_en[ch] drops at the same edge, and IRQ_STAT[ch] is set.
  - STOP while in RUN: go to IDLE, fetch_en[ch]=0 at the next edge, CNT holds its value, no irq. An ack in that same cycle is still counted. If that ack would complete the transfer, completion wins and IRQ_STAT is set.
  - STOP while in IDLE: no effect.
  - fetch_ack while in IDLE is ignored.
- A LEN[ch] write while channel ch is in RUN is ignored; LEN holds. LEN writes while IDLE take effect immediately.
- IRQ_STAT W1C and a hardware set of the same bit in the same cycle: the set wins.
- irq is registered, so it goes high one cycle after the IRQ_STAT bit and mask bit are both 1.
- Channels are fully independent. A single START or STOP write may address several channels at once.
- Reset mid-RUN aborts asynchronously: fetch_en drops immediately and no irq is raised.

Test Plan:
1. Reset, then read 0x08, 0x0C and 0x40 -> all 0; fetch_en=0; irq=0; HREADYOUT=1; HRESP=0.
2. Write LEN0=3, IRQ_MASK=1, START=0x1. Then pulse fetch_ack[0] on 3 non-consecutive cycles -> fetch_en[0] high after the START data phase and low at the third ack edge. CNT0 reads 3, IRQ_STAT=0x1, irq high one cycle later. W1C 0x1 -> irq low.
3. LEN1=10, START=0x2, 4 acks, STOP=0x2 -> fetch_en[1] low, BUSY=0, CNT1=4, IRQ_STAT bit1=0. Then START=0x2 again -> CNT1=0 and RUN resumes.
4. LEN2=0, START=0x4 -> BUSY=0, fetch_en[2] stays 0. Then write LEN2=5 during a RUN of channel 2 (after a valid start with LEN2=2) -> LEN2 reads 2.
5. LEN0=1, LEN3=2, START=0x9, with acks on both channels every cycle -> ch0 done after 1 ack and ch3 after 2. IRQ_STAT=0x9. With mask=0x8, irq follows bit3 only.
6. Assert HRESETn low mid-RUN on channel 1 -> fetch_en clears asynchronously and all registers read reset values. Also check that W1C of bit0 in the same cycle as channel 0 completes leaves IRQ_STAT bit0=1.

Source files
------------

// File: rtl/ahblite_iq_fetch_ctrl.sv
// Multi-channel IQ fetch controller: AHB-Lite register slave with
// per-channel length/beat counting, completion status and masked irq.
module ahblite_iq_fetch_ctrl #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic [2:0]        HSIZE,
    input  logic [3:0]        HPROT,
    input  logic              HWRITE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic [31:0]       HRDATA,
    output logic              HRESP,
    output logic [NUM_CH-1:0] fetch_en,
    input  logic [NUM_CH-1:0] fetch_ack,
    output logic              irq
);

    typedef enum logic {IDLE, RUN} st_e;

    logic             valid_q;
    logic             write_q;
    logic [5:0]       addr_q;

    st_e              st_q  [NUM_CH];
    st_e              st_d  [NUM_CH];
    logic [CNT_W-1:0] cnt_q [NUM_CH];
    logic [CNT_W-1:0] cnt_d [NUM_CH];
    logic [CNT_W-1:0] len_q [NUM_CH];
    logic [CNT_W-1:0] len_d [NUM_CH];
    logic [NUM_CH-1:0] stat_q, stat_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [NUM_CH-1:0] done;
    logic              irq_q;

    logic              wr;
    logic [NUM_CH-1:0] start_v, stop_v, w1c_v;
    logic              wr_mask, wr_len;

    logic unused;
    assign unused = ^{HSIZE, HPROT, HADDR[31:8], HADDR[1:0],
                      HTRANS[0], HWDATA};

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign irq       = irq_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            valid_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
        end else if (HREADY) begin
            valid_q <= HSEL & HTRANS[1];
            write_q <= HWRITE;
            addr_q  <= HADDR[7:2];
        end
    end

    // Data-phase write decode; HWDATA is valid in this cycle.
    always_comb begin
        wr      = valid_q & write_q;
        start_v = (wr && addr_q == 6'd0) ? HWDATA[NUM_CH-1:0] : '0;
        stop_v  = (wr && addr_q == 6'd1) ? HWDATA[NUM_CH-1:0] : '0;
        w1c_v   = (wr && addr_q == 6'd3) ? HWDATA[NUM_CH-1:0] : '0;
        wr_mask = wr && addr_q == 6'd4;
        wr_len  = wr && addr_q[5:3] == 3'b001;
    end

    always_comb begin
        done   = '0;
        mask_d = wr_mask ? HWDATA[NUM_CH-1:0] : mask_q;
        for (int i = 0; i < NUM_CH; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            len_d[i] = len_q[i];
            unique case (st_q[i])
                IDLE: begin
                    if (wr_len && addr_q[2:0] == 3'(i))
                        len_d[i] = HWDATA[CNT_W-1:0];
                    if (start_v[i] && len_q[i] != '0) begin
                        st_d[i]  = RUN;
                        cnt_d[i] = '0;
                    end
                end
                RUN: begin
                    if (fetch_ack[i]) begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        done[i]  = (cnt_q[i] + CNT_W'(1)) == len_q[i];
                    end
                    if (done[i] || stop_v[i])
                        st_d[i] = IDLE;
                end
                default: st_d[i] = IDLE;
            endcase
        end
        // Hardware completion outranks a simultaneous W1C.
        stat_d = (stat_q & ~w1c_v) | done;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                st_q[i]  <= IDLE;
                cnt_q[i] <= '0;
                len_q[i] <= '0;
            end
            stat_q <= '0;
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
                len_q[i] <= len_d[i];
            end
            stat_q <= stat_d;
            mask_q <= mask_d;
            irq_q  <= |(stat_q & mask_q);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++)
            fetch_en[i] = st_q[i] == RUN;
    end

    always_comb begin
        HRDATA = '0;
        if (valid_q && !write_q) begin
            unique case (addr_q)
                6'd2:    HRDATA = 32'(fetch_en);
                6'd3:    HRDATA = 32'(stat_q);
                6'd4:    HRDATA = 32'(mask_q);
                default: HRDATA = '0;
            endcase
            for (int i = 0; i < NUM_CH; i++) begin
                if (addr_q[2:0] == 3'(i)) begin
                    if (addr_q[5:3] == 3'b001)
                        HRDATA = 32'(len_q[i]);
                    if (addr_q[5:3] == 3'b010)
                        HRDATA = 32'(cnt_q[i]);
                end
            end
        end
    end

endmodule
